two_bit_decoder_seq: RTL and testbench

//  Sequential decoder for the 105-bit two-dimensional product code; the receive-side counterpart of the 44-bit encoder.

---
 rtl/two_bit_decoder_seq.sv | 217 +++++++++++++++++++++
 tb/tb_two_bit_decoder_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/two_bit_decoder_seq.sv
// rtl/two_bit_decoder_seq.sv - sequential 105-bit product-code decoder (optional DEC_ERR_STATS_EN statistics)
module two_bit_decoder_seq #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [104:0]      codeword_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [43:0]       data_out,
    output logic [3:0]        col_fix_cnt,
    output logic [2:0]        row_fix_cnt,
    output logic [STAT_W-1:0] stat_col_total,
    output logic [STAT_W-1:0] stat_row_total
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COL,
        S_ROW,
        S_OUT
    } state_t;

    // Syndrome of a Hamming(7,4) word: bit j of the vector is code position j+1.
    function automatic logic [2:0] syn7(input logic [6:0] c);
        logic [2:0] s;
        s = '0;
        for (int j = 0; j < 7; j++) begin
            if (c[j]) s = s ^ 3'(j + 1);
        end
        return s;
    endfunction

    // Flip the position named by the syndrome and pull out data positions 3,5,6,7.
    function automatic logic [3:0] fix7(input logic [6:0] c, input logic [2:0] s);
        logic [6:0] f;
        f = c;
        if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
        return {f[2], f[4], f[5], f[6]};
    endfunction

    // Syndrome of a Hamming(15,11) word: bit j of the vector is code position j+1.
    function automatic logic [3:0] syn15(input logic [14:0] c);
        logic [3:0] s;
        s = '0;
        for (int j = 0; j < 15; j++) begin
            if (c[j]) s = s ^ 4'(j + 1);
        end
        return s;
    endfunction

    // Correct a single error and return the 11 data positions, lowest position as MSB.
    function automatic logic [10:0] fix15(input logic [14:0] c, input logic [3:0] s);
        logic [14:0] f;
        f = c;
        if (s != 4'd0) f[s - 4'd1] = ~f[s - 4'd1];
        return {f[2], f[4], f[5], f[6], f[8], f[9], f[10], f[11], f[12], f[13], f[14]};
    endfunction

    // Inverse of the encoder's interleave, which places payload bit (7*i mod 44) at buffer bit i.
    function automatic logic [43:0] deinterleave(input logic [43:0] b);
        logic [43:0] d;
        d = '0;
        for (int i = 0; i < 44; i++) begin
            d[(7 * i) % 44] = b[i];
        end
        return d;
    endfunction

    state_t        r_state;
    state_t        w_next;
    logic [104:0]  r_cw;
    logic [3:0]    r_col_idx;
    logic [1:0]    r_row_idx;
    logic [14:0]   r_row [4];
    logic [43:0]   r_deint;
    logic [3:0]    r_col_fix;
    logic [2:0]    r_row_fix;

    logic [6:0]    w_col_word;
    logic [2:0]    w_col_syn;
    logic [3:0]    w_col_data;
    logic [14:0]   w_row_word;
    logic [3:0]    w_row_syn;
    logic [10:0]   w_row_data;
    logic [43:0]   w_deint_next;

    // Column decoder: select the column addressed by r_col_idx and correct it.
    always_comb begin
        w_col_word = '0;
        for (int i = 0; i < 15; i++) begin
            if (r_col_idx == 4'(i)) w_col_word = r_cw[i*7 +: 7];
        end
        w_col_syn  = syn7(w_col_word);
        w_col_data = fix7(w_col_word, w_col_syn);
    end

    // Row decoder: correct the row addressed by r_row_idx and merge it into the buffer.
    always_comb begin
        w_row_word   = r_row[r_row_idx];
        w_row_syn    = syn15(w_row_word);
        w_row_data   = fix15(w_row_word, w_row_syn);
        w_deint_next = r_deint;
        case (r_row_idx)
            2'd0:    w_deint_next[43:33] = w_row_data;
            2'd1:    w_deint_next[32:22] = w_row_data;
            2'd2:    w_deint_next[21:11] = w_row_data;
            default: w_deint_next[10:0]  = w_row_data;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_COL;
            end
            S_COL: begin
                if (r_col_idx == 4'd14) w_next = S_ROW;
            end
            S_ROW: begin
                if (r_row_idx == 2'd3) w_next = S_OUT;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch on accept, fill rows column by column, then rows into the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cw      <= '0;
            r_col_idx <= '0;
            r_row_idx <= '0;
            r_deint   <= '0;
            r_col_fix <= '0;
            r_row_fix <= '0;
            for (int k = 0; k < 4; k++) r_row[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cw      <= codeword_in;
                        r_col_idx <= '0;
                        r_row_idx <= '0;
                        r_col_fix <= '0;
                        r_row_fix <= '0;
                        for (int k = 0; k < 4; k++) r_row[k] <= '0;
                    end
                end
                S_COL: begin
                    r_row[0][4'd14 - r_col_idx] <= w_col_data[3];
                    r_row[1][4'd14 - r_col_idx] <= w_col_data[2];
                    r_row[2][4'd14 - r_col_idx] <= w_col_data[1];
                    r_row[3][4'd14 - r_col_idx] <= w_col_data[0];
                    if (w_col_syn != 3'd0) r_col_fix <= r_col_fix + 4'd1;
                    r_col_idx <= r_col_idx + 4'd1;
                end
                S_ROW: begin
                    r_deint <= w_deint_next;
                    if (w_row_syn != 4'd0) r_row_fix <= r_row_fix + 3'd1;
                    r_row_idx <= r_row_idx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign data_out    = deinterleave(r_deint);
    assign col_fix_cnt = r_col_fix;
    assign row_fix_cnt = r_row_fix;

`ifdef DEC_ERR_STATS_EN
    localparam int SW1 = STAT_W + 1;

    logic [STAT_W-1:0] r_stat_col;
    logic [STAT_W-1:0] r_stat_row;
    logic [STAT_W:0]   w_col_sum;
    logic [STAT_W:0]   w_row_sum;

    assign w_col_sum = {1'b0, r_stat_col} + SW1'(r_col_fix);
    assign w_row_sum = {1'b0, r_stat_row} + SW1'(r_row_fix);

    // Saturating accumulation of per-word correction counts at each output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_col <= '0;
            r_stat_row <= '0;
        end else if (out_valid && out_ready) begin
            r_stat_col <= w_col_sum[STAT_W] ? '1 : w_col_sum[STAT_W-1:0];
            r_stat_row <= w_row_sum[STAT_W] ? '1 : w_row_sum[STAT_W-1:0];
        end
    end

    assign stat_col_total = r_stat_col;
    assign stat_row_total = r_stat_row;
`else
    assign stat_col_total = '0;
    assign stat_row_total = '0;
`endif

endmodule

// File: tb/tb_two_bit_decoder_seq.sv
// tb/tb_two_bit_decoder_seq.sv - self-checking bench for two_bit_decoder_seq
module tb_two_bit_decoder_seq;

    localparam int STAT_W   = 4;
    localparam int STAT_MAX = 15;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [104:0]      codeword_in;
    logic              out_valid;
    logic              out_ready;
    logic [43:0]       data_out;
    logic [3:0]        col_fix_cnt;
    logic [2:0]        row_fix_cnt;
    logic [STAT_W-1:0] stat_col_total;
    logic [STAT_W-1:0] stat_row_total;

    two_bit_decoder_seq #(.STAT_W(STAT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .codeword_in    (codeword_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .col_fix_cnt    (col_fix_cnt),
        .row_fix_cnt    (row_fix_cnt),
        .stat_col_total (stat_col_total),
        .stat_row_total (stat_row_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [43:0]  payload;
        logic [104:0] flip;
        logic [3:0]   ecol;
        logic [2:0]   erow;
        int           hold;
        bit           noise;
    } vec_t;

    typedef struct {
        logic [43:0] data;
        logic [3:0]  col;
        logic [2:0]  row;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_sc  = 0;
    int   exp_sr  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [6:0] enc74(input logic [3:0] d);
        logic [6:0] c;
        c    = '0;
        c[2] = d[3];
        c[4] = d[2];
        c[5] = d[1];
        c[6] = d[0];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        return c;
    endfunction

    function automatic logic [14:0] enc1511(input logic [10:0] d);
        logic [14:0] c;
        logic        p;
        c = '0;
        {c[2], c[4], c[5], c[6], c[8], c[9], c[10], c[11], c[12], c[13], c[14]} = d;
        for (int pw = 1; pw <= 8; pw = pw * 2) begin
            p = 1'b0;
            for (int qq = 1; qq <= 15; qq++) begin
                if ((qq & pw) != 0 && qq != pw) p = p ^ c[qq-1];
            end
            c[pw-1] = p;
        end
        return c;
    endfunction

    function automatic logic [104:0] encode(input logic [43:0] payload);
        logic [43:0]  b;
        logic [14:0]  rc [4];
        logic [104:0] cw;
        for (int i = 0; i < 44; i++) b[i] = payload[(7 * i) % 44];
        for (int r = 0; r < 4; r++) rc[r] = enc1511(b[43 - 11*r -: 11]);
        for (int i = 0; i < 15; i++)
            cw[i*7 +: 7] = enc74({rc[0][14-i], rc[1][14-i], rc[2][14-i], rc[3][14-i]});
        return cw;
    endfunction

    task automatic run_word(input vec_t v);
        exp_t e;
        int   t;
        int   lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid    = 1'b1;
        codeword_in = encode(v.payload) ^ v.flip;
        out_ready   = 1'b0;
        q.push_back('{v.payload, v.ecol, v.erow});
        @(negedge clk);
        in_valid    = 1'b0;
        codeword_in = '0;
        lat = 1;
        chk("busy_in_ready", in_ready, 0);
        while (!out_valid && lat < 40) begin
            if (v.noise && lat >= 2 && lat <= 10) begin
                in_valid    = 1'b1;
                codeword_in = {41'($urandom), $urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, 20);
        e = q.pop_front();
        if (out_valid) begin
            chk("data_out", data_out, e.data);
            chk("col_fix_cnt", col_fix_cnt, e.col);
            chk("row_fix_cnt", row_fix_cnt, e.row);
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                chk("hold_valid", out_valid, 1);
                chk("hold_data", data_out, e.data);
                chk("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("post_hs_valid", out_valid, 0);
            chk("post_hs_in_ready", in_ready, 1);
`ifdef DEC_ERR_STATS_EN
            exp_sc = (exp_sc + int'(e.col) > STAT_MAX) ? STAT_MAX : exp_sc + int'(e.col);
            exp_sr = (exp_sr + int'(e.row) > STAT_MAX) ? STAT_MAX : exp_sr + int'(e.row);
`endif
            chk("stat_col_total", stat_col_total, exp_sc);
            chk("stat_row_total", stat_row_total, exp_sr);
        end
    endtask

    initial begin
        vec_t         vecs[7];
        vec_t         v;
        logic [104:0] f;
        logic [43:0]  p;
        int           seen;

        f = '0;
        for (int i = 0; i < 15; i++) f[i*7 + 2] = 1'b1;
        vecs[0] = '{44'h0,           105'h0,     4'd0,  3'd0, 0,  1'b0};
        vecs[1] = '{44'hA5A5A5A5A5A, 105'h8,     4'd1,  3'd0, 0,  1'b0};
        vecs[2] = '{44'hFFFFFFFFFFF, f,          4'd15, 3'd0, 0,  1'b0};
        vecs[3] = '{44'h12345678ABC, 105'h0,     4'd0,  3'd0, 10, 1'b0};
        f = '0;
        f[0] = 1'b1; f[1] = 1'b1;
        f[7] = 1'b1; f[10] = 1'b1;
        f[15] = 1'b1; f[17] = 1'b1;
        vecs[4] = '{44'h0BADC0FFEE1, f,          4'd3,  3'd3, 2,  1'b0};
        f = '0;
        f[41] = 1'b1; f[67] = 1'b1;
        vecs[5] = '{44'h3C3C3C3C3C3, f,          4'd2,  3'd0, 0,  1'b1};
        f = '0;
        f[104] = 1'b1;
        vecs[6] = '{44'h7FF00000001, f,          4'd1,  3'd0, 1,  1'b0};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        codeword_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_col_fix", col_fix_cnt, 0);
        chk("rst_row_fix", row_fix_cnt, 0);
        chk("rst_stat_col", stat_col_total, 0);
        chk("rst_stat_row", stat_row_total, 0);

        for (int i = 0; i < 7; i++) run_word(vecs[i]);

        // Reset eight cycles into a decode: result discarded, no output.
        @(negedge clk);
        in_valid    = 1'b1;
        codeword_in = encode(44'hDEADBEEF123);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_sc = 0;
        exp_sr = 0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_stat_col", stat_col_total, 0);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_output", seen, 0);
        v = '{44'h0000000001F, 105'h0, 4'd0, 3'd0, 0, 1'b0};
        run_word(v);

        // Twenty words with one column error each drive the column total to saturation.
        for (int w = 0; w < 20; w++) begin
            f = '0;
            f[(w % 15) * 7 + $urandom_range(0, 6)] = 1'b1;
            p = {12'($urandom), $urandom};
            v = '{p, f, 4'd1, 3'd0, 0, 1'b0};
            run_word(v);
        end
`ifdef DEC_ERR_STATS_EN
        chk("stat_col_saturated", stat_col_total, STAT_MAX);
`else
        chk("stat_col_disabled", stat_col_total, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
